// File: rtl/msrv32_lsu_if.sv
// -----------------------------------------------------------------------------
// msrv32_lsu_if
// Groups the core-side request signals and the data-memory bus of the
// load/store unit.
//   master : LSU view. It drives the memory request, the load result and the
//            status pulses.
//   slave  : core/memory view. It drives the start request, the operands and
//            the memory response.
// Signals:
//   start_in, is_store_in, funct3_in, addr_in, rs2_in : operation request
//   ms_riscv32_mp_dm*_in                              : memory response
//   ms_riscv32_mp_dm*_out                             : memory request
//   load_data_out, busy_out, done_out,
//   misaligned_out, timeout_out                       : result and status
// -----------------------------------------------------------------------------
interface msrv32_lsu_if;
    logic        start_in;
    logic        is_store_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] rs2_in;
    logic [31:0] ms_riscv32_mp_dmdata_in;
    logic        ms_riscv32_mp_dmready_in;
    logic [31:0] ms_riscv32_mp_dmaddr_out;
    logic [31:0] ms_riscv32_mp_dmdata_out;
    logic        ms_riscv32_mp_dmwr_req_out;
    logic        ms_riscv32_mp_dmrd_req_out;
    logic [3:0]  ms_riscv32_mp_dmwr_mask_out;
    logic [31:0] load_data_out;
    logic        busy_out;
    logic        done_out;
    logic        misaligned_out;
    logic        timeout_out;

    modport master (
        input  start_in, is_store_in, funct3_in, addr_in, rs2_in,
        input  ms_riscv32_mp_dmdata_in, ms_riscv32_mp_dmready_in,
        output ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out,
        output ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmrd_req_out,
        output ms_riscv32_mp_dmwr_mask_out,
        output load_data_out, busy_out, done_out, misaligned_out, timeout_out
    );

    modport slave (
        output start_in, is_store_in, funct3_in, addr_in, rs2_in,
        output ms_riscv32_mp_dmdata_in, ms_riscv32_mp_dmready_in,
        input  ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out,
        input  ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmrd_req_out,
        input  ms_riscv32_mp_dmwr_mask_out,
        input  load_data_out, busy_out, done_out, misaligned_out, timeout_out
    );
endinterface

// File: rtl/msrv32_lsu.sv
// -----------------------------------------------------------------------------
// msrv32_lsu
// RV32I load/store unit. It takes the ALU result as the effective address and
// runs one request/ready access on the data-memory bus. It handles byte-lane
// steering, write masks, sign/zero extension, alignment rejection and a
// bounded wait.
// Ports:
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : asynchronous active-high reset
//   bus                  : msrv32_lsu_if.master (request, memory bus, status)
// Parameters:
//   MAX_WAIT : number of REQ cycles without ready before the access is
//              abandoned (1..255)
// -----------------------------------------------------------------------------
module msrv32_lsu #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          ms_riscv32_mp_clk_in,
    input  logic          ms_riscv32_mp_rst_in,
    msrv32_lsu_if.master  bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [1:0]  r_size, w_size_nxt;          // 00 byte, 01 half, 10 word
    logic        r_unsigned, w_unsigned_nxt;
    logic        r_store, w_store_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_mask, w_mask_nxt;
    logic        r_rd_req, w_rd_req_nxt;
    logic        r_wr_req, w_wr_req_nxt;
    logic [31:0] r_ldata, w_ldata_nxt;
    logic        r_done, w_done_nxt;
    logic        r_misal, w_misal_nxt;
    logic        r_tmo, w_tmo_nxt;

    logic [1:0]  w_req_size;
    logic        w_aligned;
    logic [3:0]  w_req_mask;
    logic [31:0] w_req_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_ext_data;

    // Decode the incoming request; funct3[1:0]=11 folds into word size
    always_comb begin
        w_req_size  = (bus.funct3_in[1:0] == 2'b11) ? 2'b10 : bus.funct3_in[1:0];
        w_aligned   = 1'b1;
        w_req_mask  = 4'b1111;
        w_req_wdata = bus.rs2_in;
        case (w_req_size)
            2'b00: begin
                w_req_mask  = 4'b0001 << bus.addr_in[1:0];
                w_req_wdata = {4{bus.rs2_in[7:0]}};
            end
            2'b01: begin
                w_aligned   = ~bus.addr_in[0];
                w_req_mask  = bus.addr_in[1] ? 4'b1100 : 4'b0011;
                w_req_wdata = {2{bus.rs2_in[15:0]}};
            end
            default: begin
                w_aligned   = (bus.addr_in[1:0] == 2'b00);
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_lane_byte = bus.ms_riscv32_mp_dmdata_in[7:0];
            2'b01:   w_lane_byte = bus.ms_riscv32_mp_dmdata_in[15:8];
            2'b10:   w_lane_byte = bus.ms_riscv32_mp_dmdata_in[23:16];
            default: w_lane_byte = bus.ms_riscv32_mp_dmdata_in[31:24];
        endcase
        w_lane_half = r_addr[1] ? bus.ms_riscv32_mp_dmdata_in[31:16]
                                : bus.ms_riscv32_mp_dmdata_in[15:0];
        case (r_size)
            2'b00:   w_ext_data = {{24{~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_ext_data = {{16{~r_unsigned & w_lane_half[15]}}, w_lane_half};
            default: w_ext_data = bus.ms_riscv32_mp_dmdata_in;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_size_nxt     = r_size;
        w_unsigned_nxt = r_unsigned;
        w_store_nxt    = r_store;
        w_wdata_nxt    = r_wdata;
        w_mask_nxt     = r_mask;
        w_rd_req_nxt   = r_rd_req;
        w_wr_req_nxt   = r_wr_req;
        w_ldata_nxt    = r_ldata;
        w_done_nxt     = 1'b0;
        w_misal_nxt    = 1'b0;
        w_tmo_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start_in) begin
                    if (!w_aligned) begin
                        w_misal_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = S_REQ;
                        w_cnt_nxt      = '0;
                        w_addr_nxt     = bus.addr_in;
                        w_size_nxt     = w_req_size;
                        w_unsigned_nxt = bus.funct3_in[2] & ~bus.is_store_in;
                        w_store_nxt    = bus.is_store_in;
                        w_wdata_nxt    = w_req_wdata;
                        w_mask_nxt     = w_req_mask;
                        w_rd_req_nxt   = ~bus.is_store_in;
                        w_wr_req_nxt   = bus.is_store_in;
                    end
                end
            end
            S_REQ: begin
                // Completion takes priority over an expiring wait counter
                if (bus.ms_riscv32_mp_dmready_in) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_rd_req_nxt = 1'b0;
                    w_wr_req_nxt = 1'b0;
                    w_mask_nxt   = 4'b0000;
                    w_done_nxt   = 1'b1;
                    if (!r_store) begin
                        w_ldata_nxt = w_ext_data;
                    end
                end else if (r_cnt == LAST_WAIT) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_rd_req_nxt = 1'b0;
                    w_wr_req_nxt = 1'b0;
                    w_mask_nxt   = 4'b0000;
                    w_tmo_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_store    <= 1'b0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_ldata    <= '0;
            r_done     <= 1'b0;
            r_misal    <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_size     <= w_size_nxt;
            r_unsigned <= w_unsigned_nxt;
            r_store    <= w_store_nxt;
            r_wdata    <= w_wdata_nxt;
            r_mask     <= w_mask_nxt;
            r_rd_req   <= w_rd_req_nxt;
            r_wr_req   <= w_wr_req_nxt;
            r_ldata    <= w_ldata_nxt;
            r_done     <= w_done_nxt;
            r_misal    <= w_misal_nxt;
            r_tmo      <= w_tmo_nxt;
        end
    end

    assign bus.ms_riscv32_mp_dmaddr_out    = {r_addr[31:2], 2'b00};
    assign bus.ms_riscv32_mp_dmdata_out    = r_wdata;
    assign bus.ms_riscv32_mp_dmwr_req_out  = r_wr_req;
    assign bus.ms_riscv32_mp_dmrd_req_out  = r_rd_req;
    assign bus.ms_riscv32_mp_dmwr_mask_out = r_mask;
    assign bus.load_data_out               = r_ldata;
    assign bus.busy_out                    = (r_state == S_REQ);
    assign bus.done_out                    = r_done;
    assign bus.misaligned_out              = r_misal;
    assign bus.timeout_out                 = r_tmo;
endmodule

// File: tb/tb_msrv32_lsu.sv
// -----------------------------------------------------------------------------
// tb_msrv32_lsu
// Self-checking bench for msrv32_lsu. Expected completions (pulse kind, load
// result, latency in cycles after the start edge) are queued when an access
// is issued. They are popped and compared when the DUT raises a pulse.
// -----------------------------------------------------------------------------
module tb_msrv32_lsu;
    localparam int unsigned MAX_WAIT = 15;
    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_MIS  = 3'b010;
    localparam logic [2:0] K_TMO  = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    msrv32_lsu_if bus ();

    msrv32_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   mem_waits = 0;
    int   wcnt = 0;

    // Memory responder: raises ready after mem_waits request cycles
    always @(negedge clk) begin
        if (bus.ms_riscv32_mp_dmrd_req_out || bus.ms_riscv32_mp_dmwr_req_out) begin
            bus.ms_riscv32_mp_dmready_in = (wcnt >= mem_waits);
            wcnt = wcnt + 1;
        end else begin
            bus.ms_riscv32_mp_dmready_in = 1'b0;
            wcnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.start_in    = 1'b1;
        bus.is_store_in = st;
        bus.funct3_in   = f3;
        bus.addr_in     = a;
        bus.rs2_in      = d;
        @(posedge clk); #1;
        bus.start_in    = 1'b0;
    endtask

    // Waits for the next status pulse; 'first' labels the next sampled cycle
    task automatic wait_result(input int first, input int last,
                               output logic [2:0] kind, output logic [31:0] data,
                               output int lat);
        kind = K_NONE; data = '0; lat = -1;
        for (int n = first; n <= last; n++) begin
            @(negedge clk);
            if ({bus.timeout_out, bus.misaligned_out, bus.done_out} != 3'b000) begin
                kind = {bus.timeout_out, bus.misaligned_out, bus.done_out};
                data = bus.load_data_out;
                lat  = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_in = 1'b0; bus.is_store_in = 1'b0; bus.funct3_in = 3'b000;
        bus.addr_in = '0; bus.rs2_in = '0; bus.ms_riscv32_mp_dmdata_in = '0;
        @(negedge clk);
        n_checks++;
        if ({bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out,
             bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmrd_req_out,
             bus.ms_riscv32_mp_dmwr_mask_out, bus.load_data_out, bus.busy_out,
             bus.done_out, bus.misaligned_out, bus.timeout_out} !== 106'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h data=%h rd=%b wr=%b mask=%b ld=%h busy=%b expected all zero",
                     bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmdata_out,
                     bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out,
                     bus.ms_riscv32_mp_dmwr_mask_out, bus.load_data_out, bus.busy_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy_out, bus.done_out, bus.misaligned_out, bus.timeout_out,
             bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out} !== 6'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b mis=%b tmo=%b expected 0",
                     bus.busy_out, bus.done_out, bus.misaligned_out, bus.timeout_out);
        end
    endtask

    task automatic check_sb(input string name, input logic [2:0] kind,
                            input logic [31:0] data, input int lat);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: pulse kind=%b with no expected entry", name, kind);
            return;
        end
        e = sb.pop_front();
        if (kind !== e.kind || data !== e.data || lat != e.lat) begin
            n_fail++;
            $display("FAIL %s: got kind=%b data=%h lat=%0d expected kind=%b data=%h lat=%0d",
                     name, kind, data, lat, e.kind, e.data, e.lat);
        end
    endtask

    task automatic test_load_byte();
        logic [2:0] k; logic [31:0] d; int l;
        mem_waits = 0;
        bus.ms_riscv32_mp_dmdata_in = 32'h80FF_1234;
        sb.push_back('{K_DONE, 32'hFFFF_FF80, 2});
        issue(1'b0, 3'b000, 32'h0000_1003, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out, bus.busy_out,
             bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmwr_mask_out}
            !== {3'b101, 32'h0000_1000, 4'b1000}) begin
            n_fail++;
            $display("FAIL lb_request: got rd=%b wr=%b busy=%b addr=%h mask=%b expected rd=1 wr=0 busy=1 addr=00001000 mask=1000",
                     bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out, bus.busy_out,
                     bus.ms_riscv32_mp_dmaddr_out, bus.ms_riscv32_mp_dmwr_mask_out);
        end
        wait_result(2, 40, k, d, l);
        check_sb("lb_result", k, d, l);
        n_checks++;
        if ({bus.busy_out, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_mask_out} !== 6'd0) begin
            n_fail++;
            $display("FAIL lb_done_idle: got busy=%b rd=%b mask=%b expected 0 0 0000",
                     bus.busy_out, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_mask_out);
        end
    endtask

    task automatic test_store_half();
        logic [2:0] k; logic [31:0] d; int l; int bad;
        mem_waits = 3;
        bad = 0;
        sb.push_back('{K_DONE, 32'hFFFF_FF80, 5});
        issue(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if ({bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmrd_req_out,
                 bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out,
                 bus.ms_riscv32_mp_dmaddr_out} !== {2'b10, 32'hBEEF_BEEF, 4'b1100, 32'h0000_2000})
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sh_request: got %0d bad request cycles expected 0 (last data=%h mask=%b)",
                     bad, bus.ms_riscv32_mp_dmdata_out, bus.ms_riscv32_mp_dmwr_mask_out);
        end
        wait_result(5, 40, k, d, l);
        check_sb("sh_result", k, d, l);
    endtask

    task automatic test_misaligned();
        logic [2:0] k; logic [31:0] d; int l;
        sb.push_back('{K_MIS, 32'hFFFF_FF80, 1});
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        wait_result(1, 10, k, d, l);
        check_sb("lw_misaligned", k, d, l);
        n_checks++;
        if ({bus.busy_out, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL misaligned_no_req: got busy=%b rd=%b wr=%b expected 000",
                     bus.busy_out, bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.misaligned_out, bus.busy_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL misaligned_one_cycle: got mis=%b busy=%b expected 00",
                     bus.misaligned_out, bus.busy_out);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] k; logic [31:0] d; int l; int bad;
        mem_waits = 255;
        bad = 0;
        sb.push_back('{K_TMO, 32'hFFFF_FF80, 16});
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if ({bus.ms_riscv32_mp_dmrd_req_out, bus.busy_out, bus.timeout_out, bus.done_out} !== 4'b1100)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL timeout_req_held: got %0d bad cycles in 1..15 expected 0", bad);
        end
        wait_result(16, 40, k, d, l);
        check_sb("timeout_result", k, d, l);
        n_checks++;
        if ({bus.ms_riscv32_mp_dmrd_req_out, bus.busy_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_dropped: got rd=%b busy=%b expected 00",
                     bus.ms_riscv32_mp_dmrd_req_out, bus.busy_out);
        end
    endtask

    task automatic test_ready_at_expiry();
        logic [2:0] k; logic [31:0] d; int l;
        mem_waits = 14;
        bus.ms_riscv32_mp_dmdata_in = 32'h1234_5678;
        sb.push_back('{K_DONE, 32'h1234_5678, 16});
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        wait_result(1, 40, k, d, l);
        check_sb("ready_at_expiry", k, d, l);
    endtask

    task automatic test_lhu();
        logic [2:0] k; logic [31:0] d; int l;
        mem_waits = 1;
        bus.ms_riscv32_mp_dmdata_in = 32'h9ABC_0000;
        sb.push_back('{K_DONE, 32'h0000_9ABC, 3});
        issue(1'b0, 3'b101, 32'h0000_3002, 32'h0);
        wait_result(1, 40, k, d, l);
        check_sb("lhu_result", k, d, l);
    endtask

    task automatic test_back_to_back();
        logic [2:0] k; logic [31:0] d; int l;
        mem_waits = 0;
        bus.ms_riscv32_mp_dmdata_in = 32'h8001_7F00;
        sb.push_back('{K_DONE, 32'h0000_007F, 2});
        sb.push_back('{K_DONE, 32'hFFFF_8001, 2});
        issue(1'b0, 3'b000, 32'h0000_1001, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        // Second request raised in the cycle the first one reports done
        bus.start_in = 1'b1; bus.is_store_in = 1'b0;
        bus.funct3_in = 3'b001; bus.addr_in = 32'h0000_1002;
        @(negedge clk);
        k = {bus.timeout_out, bus.misaligned_out, bus.done_out};
        check_sb("b2b_first", k, bus.load_data_out, 2);
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_mask_out,
             bus.ms_riscv32_mp_dmaddr_out} !== {1'b1, 4'b1100, 32'h0000_1000}) begin
            n_fail++;
            $display("FAIL b2b_second_req: got rd=%b mask=%b addr=%h expected 1 1100 00001000",
                     bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_mask_out,
                     bus.ms_riscv32_mp_dmaddr_out);
        end
        wait_result(2, 40, k, d, l);
        check_sb("b2b_second", k, d, l);
    endtask

    task automatic test_reset_mid();
        logic [2:0] k; logic [31:0] d; int l;
        mem_waits = 255;
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out,
             bus.ms_riscv32_mp_dmwr_mask_out, bus.busy_out, bus.done_out,
             bus.misaligned_out, bus.timeout_out, bus.load_data_out} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got rd=%b wr=%b mask=%b busy=%b ld=%h expected all zero",
                     bus.ms_riscv32_mp_dmrd_req_out, bus.ms_riscv32_mp_dmwr_req_out,
                     bus.ms_riscv32_mp_dmwr_mask_out, bus.busy_out, bus.load_data_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_result(1, 4, k, d, l);
        n_checks++;
        if (k !== K_NONE) begin
            n_fail++;
            $display("FAIL reset_mid_no_pulse: got kind=%b expected %b", k, K_NONE);
        end
        mem_waits = 0;
        sb.push_back('{K_DONE, 32'h0000_0000, 2});
        issue(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        @(negedge clk);
        n_checks++;
        if ({bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmrd_req_out,
             bus.ms_riscv32_mp_dmwr_mask_out, bus.ms_riscv32_mp_dmdata_out,
             bus.ms_riscv32_mp_dmaddr_out} !== {2'b10, 4'b1111, 32'hCAFE_F00D, 32'h0000_0040}) begin
            n_fail++;
            $display("FAIL sw_after_reset_req: got wr=%b rd=%b mask=%b data=%h addr=%h expected 1 0 1111 cafef00d 00000040",
                     bus.ms_riscv32_mp_dmwr_req_out, bus.ms_riscv32_mp_dmrd_req_out,
                     bus.ms_riscv32_mp_dmwr_mask_out, bus.ms_riscv32_mp_dmdata_out,
                     bus.ms_riscv32_mp_dmaddr_out);
        end
        wait_result(2, 40, k, d, l);
        check_sb("sw_after_reset", k, d, l);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_ready_at_expiry();
        test_lhu();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/msrv32_lsu.md
# msrv32_lsu

Load/store unit sitting directly downstream of `msrv32_alu`. It takes the ALU's 32-bit `result_out` as the effective address of a RISC-V RV32I load or store. It runs a request/ready handshake on the data-memory bus, applying byte-lane steering, write masks, sign/zero extension and alignment checks. It stalls the core through `busy_out` until the access completes, faults or times out.

## Interface
- `MAX_WAIT`, 15: number of request cycles without `ms_riscv32_mp_dmready_in` before the access is abandoned (1–255).
- `ms_riscv32_mp_clk_in` in 1: single clock; all state changes on the rising edge.
- `ms_riscv32_mp_rst_in` in 1: reset, asynchronous and active-high.
- `start_in` in 1: one-cycle request for a new memory operation; sampled only in IDLE.
- `is_store_in` in 1: 1 = store, 0 = load.
- `funct3_in` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Bit 2 is ignored for stores. `funct3_in[1:0]`=11 is treated as W.
- `addr_in` in 32: effective address (ALU `result_out`).
- `rs2_in` in 32: store data.
- `ms_riscv32_mp_dmdata_in` in 32: memory read data, valid when ready is high.
- `ms_riscv32_mp_dmready_in` in 1: memory completes the current request.
- `ms_riscv32_mp_dmaddr_out` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `ms_riscv32_mp_dmdata_out` out 32: lane-replicated store data.
- `ms_riscv32_mp_dmwr_req_out` out 1: write request.
- `ms_riscv32_mp_dmrd_req_out` out 1: read request.
- `ms_riscv32_mp_dmwr_mask_out` out 4: byte enables, bit i = byte lane i.
- `load_data_out` out 32: extended load result; holds its value until the next load completes.
- `busy_out` out 1: core stall; high while not IDLE.
- `done_out` out 1: one-cycle pulse when an access completes.
- `misaligned_out` out 1: one-cycle pulse when an access is rejected for misalignment.
- `timeout_out` out 1: one-cycle pulse when an access is abandoned after `MAX_WAIT`.

## Operation
- States: IDLE, REQ.
- Reset sets state to IDLE, wait counter to 0, and all outputs to 0.
- IDLE with `start_in`=1:
  - Alignment check: H/HU require `addr[0]`=0; W requires `addr[1:0]`=0. B/BU are always aligned.
  - Misaligned: next cycle `misaligned_out`=1 for one cycle. State stays IDLE, no bus request is issued, and `load_data_out` is unchanged.
  - Aligned: register address, size, signedness, store data and mask, then enter REQ.
- Store data:
  - B: `{4{rs2[7:0]}}`, mask `4'b0001<<addr[1:0]`.
  - H: `{2{rs2[15:0]}}`, mask 0011 (`addr[1]`=0) or 1100.
  - W: `rs2`, mask 1111.
- Loads drive the same size-derived mask as byte enables.
- REQ:
  - Exactly one of `ms_riscv32_mp_dmrd_req_out`/`ms_riscv32_mp_dmwr_req_out` is high.
  - Address, data and mask are held stable throughout.
  - The wait counter increments on each REQ cycle with ready low.
- Ready sampled high in REQ:
  - For loads, select the byte/halfword lane by `addr[1:0]` and sign-extend (B/H) or zero-extend (BU/HU) into `load_data_out`.
  - Next cycle: IDLE, `done_out`=1, requests and mask low.
- Counter reaches `MAX_WAIT` with ready still low: next cycle IDLE, `timeout_out`=1, requests dropped, `load_data_out` unchanged.
- Ready high on the same edge the counter would expire: completion wins; no timeout.
- `start_in` in REQ is ignored. The core must hold off because `busy_out` is high.
- Reset asserted mid-access: requests and all outputs go to 0 immediately (asynchronous). The access is lost and no pulse is generated.
- `done_out`, `misaligned_out` and `timeout_out` are mutually exclusive.

## Timing
- Edge 0: `start_in` sampled. Cycle 1: REQ, request and `busy_out` high.
- Zero-wait memory (ready high in cycle 1): cycle 2 has `done_out`=1, `busy_out`=0, and `load_data_out` valid. Total latency is 2 cycles.
- N wait cycles give a latency of 2+N.
- Timeout: `MAX_WAIT` REQ cycles, then the pulse. With `MAX_WAIT`=15 the pulse appears in cycle 16.
- Misaligned: pulse in cycle 1; `busy_out` never rises.
- Back-to-back: a new `start_in` is accepted in the same cycle `done_out` is high, which is IDLE.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `ms_riscv32_mp_dmready_in` to the request outputs.

## Test plan
- **Load byte, signed:** LB, addr 0x1003, memory returns 0x80FF_1234 with zero wait -> rd_req in cycle 1, dmaddr 0x1000, mask 1000; cycle 2 `done_out`=1, `load_data_out`=0xFFFF_FF80.
- **Store half:** SH, addr 0x2002, rs2 0xDEAD_BEEF, ready after 3 wait cycles -> dmdata 0xBEEF_BEEF, mask 1100, wr_req held for 4 cycles, `done_out` in cycle 5.
- **Misaligned word:** LW, addr 0x0000_0006 -> `misaligned_out` pulse in cycle 1; no request; `busy_out` stays 0; `load_data_out` unchanged.
- **Timeout:** LW, addr 0x100, ready held low, `MAX_WAIT`=15 -> rd_req high in cycles 1–15, `timeout_out` in cycle 16; with ready in cycle 15 instead, `done_out` in cycle 16 and no timeout.
- **Load halfword, unsigned:** LHU, addr 0x3002, memory 0x9ABC_0000 -> `load_data_out`=0x0000_9ABC.
- **Reset mid-access:** assert reset during REQ wait cycle 2 -> requests, mask and pulses 0 immediately; after release, a fresh SW, addr 0x40, completes normally with mask 1111.
